// File: rtl/smfro_rng_w.sv
// smfro_rng_w - parametrised self-mutual-feedback RNG core with noise injection,
// seed load + warm-up, valid/ready output and sticky online health tests.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   en         advance the core this cycle
//   seed_load  load 'seed' into the core and restart warm-up (overrides en)
//   seed       seed value
//   noise      raw entropy XORed into every core update
//   out_data   captured random word
//   out_valid  out_data holds an undelivered word
//   out_ready  consumer accepts out_data
//   busy       high while warming up
//   fault      sticky health-test failure (stuck-zero / repetition count)
module smfro_rng_w #(
  parameter int unsigned       WIDTH     = 16,
  parameter int unsigned       WARMUP    = 32,
  parameter int unsigned       REP_LIMIT = 4,
  parameter logic [WIDTH-1:0]  SEED_RST  = WIDTH'(16'hACE1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             seed_load,
  input  logic [WIDTH-1:0] seed,
  input  logic [WIDTH-1:0] noise,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic             fault
);

  localparam int unsigned WW = $clog2(WARMUP + 1);
  localparam int unsigned RW = $clog2(REP_LIMIT + 1);

  typedef enum logic [1:0] {
    ST_WARM,
    ST_RUN,
    ST_FAULT
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] s_q, s_d;
  logic [WW-1:0]    warm_cnt_q, warm_cnt_d;
  logic [RW-1:0]    rep_cnt_q, rep_cnt_d;
  logic [WIDTH-1:0] last_word_q, last_word_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             out_valid_q, out_valid_d;

  // Core next-state function
  logic             parity;
  logic [WIDTH-1:0] s_rot;
  logic [WIDTH-1:0] fb;
  logic [WIDTH-1:0] mix;
  logic [WIDTH-1:0] s_next;

  always_comb begin
    parity = ^s_q;
    // s_rot[i] = s[(i+1) mod WIDTH]
    s_rot  = {s_q[0], s_q[WIDTH-1:1]};
    fb     = {WIDTH{parity}} ^ s_q ^ s_rot;
  end

  for (genvar k = 0; k < WIDTH / 2; k++) begin : g_pair
    assign mix[2*k]   = s_q[2*k+1] ^ fb[2*k];
    assign mix[2*k+1] = s_q[2*k]   ^ fb[2*k+1];
  end

  assign s_next = mix ^ noise;

  // Control / health tests
  int unsigned rep_new;

  always_comb begin
    state_d     = state_q;
    s_d         = s_q;
    warm_cnt_d  = warm_cnt_q;
    rep_cnt_d   = rep_cnt_q;
    last_word_d = last_word_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    rep_new     = 0;

    if (seed_load) begin
      s_d         = seed;
      state_d     = ST_WARM;
      warm_cnt_d  = '0;
      rep_cnt_d   = '0;
      out_valid_d = 1'b0;
    end else if (state_q != ST_FAULT) begin
      if (en) begin
        s_d = s_next;
      end
      if (s_q == '0) begin
        // Stuck-zero wins over everything else, even with en low.
        state_d     = ST_FAULT;
        out_valid_d = 1'b0;
      end else if (state_q == ST_WARM) begin
        if (en) begin
          warm_cnt_d = WW'(32'(warm_cnt_q) + 1);
          if (32'(warm_cnt_q) + 1 >= WARMUP) begin
            state_d = ST_RUN;
          end
        end
      end else if (en && (!out_valid_q || out_ready)) begin
        // Capture edge. rep_cnt == 0 marks the first capture since warm-up,
        // so a stale last_word never extends a run across a reseed.
        if (rep_cnt_q == '0 || s_q != last_word_q) begin
          rep_new = 1;
        end else begin
          rep_new = 32'(rep_cnt_q) + 1;
        end
        rep_cnt_d = RW'(rep_new);
        if (rep_new >= REP_LIMIT) begin
          state_d     = ST_FAULT;
          out_valid_d = 1'b0;
        end else begin
          out_data_d  = s_q;
          last_word_d = s_q;
          out_valid_d = 1'b1;
        end
      end else if (out_valid_q && out_ready) begin
        out_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_WARM;
      s_q         <= SEED_RST;
      warm_cnt_q  <= '0;
      rep_cnt_q   <= '0;
      last_word_q <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      s_q         <= s_d;
      warm_cnt_q  <= warm_cnt_d;
      rep_cnt_q   <= rep_cnt_d;
      last_word_q <= last_word_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign busy      = (state_q == ST_WARM);
  assign fault     = (state_q == ST_FAULT);

endmodule

// File: tb/tb_smfro_rng_w.sv
// Self-checking bench for smfro_rng_w (WIDTH=16, WARMUP=1, REP_LIMIT=4).
// Expected words are hand-derived from the core update equations.
module tb_smfro_rng_w;

  logic        clk = 1'b0;
  logic        rst, en, seed_load, out_ready;
  logic [15:0] seed, noise;
  logic [15:0] out_data;
  logic        out_valid, busy, fault;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  smfro_rng_w #(
    .WIDTH    (16),
    .WARMUP   (1),
    .REP_LIMIT(4),
    .SEED_RST (16'hACE1)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .seed_load(seed_load),
    .seed     (seed),
    .noise    (noise),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .busy     (busy),
    .fault    (fault)
  );

  typedef struct {
    logic [15:0] seed;
    logic [15:0] noise;
    logic [15:0] exp_word;
  } vec_t;

  vec_t vecs[8];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic load(input logic [15:0] v);
    seed_load = 1'b1;
    seed      = v;
    step();
    seed_load = 1'b0;
  endtask

  initial begin
    // first captured word with WARMUP=1 is n(seed) ^ noise
    vecs[0] = '{16'h0001, 16'h0000, 16'h7FFC};
    vecs[1] = '{16'h7FFC, 16'h0000, 16'h0001};
    vecs[2] = '{16'hFFFF, 16'h0000, 16'hFFFF};
    vecs[3] = '{16'h0001, 16'h00FF, 16'h7F03};
    vecs[4] = '{16'h0003, 16'h0000, 16'h8001};
    vecs[5] = '{16'h8000, 16'h0000, 16'h7FFF};
    vecs[6] = '{16'h1234, 16'h0000, 16'hC5E9};
    vecs[7] = '{16'h1234, 16'hA5A5, 16'h604C};

    rst = 1'b1; en = 1'b0; seed_load = 1'b0; seed = '0; noise = '0; out_ready = 1'b1;
    step();
    step();
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_data",  32'(out_data),  32'd0);
    chk("rst_busy",  32'(busy),      32'd1);
    chk("rst_fault", 32'(fault),     32'd0);

    // n(0xACE1) = 0x2643
    rst = 1'b0; en = 1'b1;
    step();
    chk("rst_run_busy",  32'(busy),      32'd0);
    chk("rst_run_valid", 32'(out_valid), 32'd0);
    step();
    chk("rst_first_valid", 32'(out_valid), 32'd1);
    chk("rst_first_word",  32'(out_data),  32'h2643);

    // en=0: a transfer still clears out_valid
    en = 1'b0;
    step();
    chk("en0_transfer_clear", 32'(out_valid), 32'd0);
    en = 1'b1;

    // table of single-advance words
    for (int i = 0; i < 8; i++) begin
      noise = vecs[i].noise;
      load(vecs[i].seed);
      chk($sformatf("vec%0d_busy", i),  32'(busy),      32'd1);
      chk($sformatf("vec%0d_v0", i),    32'(out_valid), 32'd0);
      step();
      chk($sformatf("vec%0d_run", i),   32'(busy),      32'd0);
      step();
      chk($sformatf("vec%0d_valid", i), 32'(out_valid), 32'd1);
      chk($sformatf("vec%0d_word", i),  32'(out_data),  32'(vecs[i].exp_word));
    end
    noise = '0;

    // rst while a word is pending
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rst_mid_valid", 32'(out_valid), 32'd0);
    chk("rst_mid_data",  32'(out_data),  32'd0);
    chk("rst_mid_busy",  32'(busy),      32'd1);

    // zero seed with en low: stuck-zero trips one edge after the load
    en = 1'b0;
    load(16'h0000);
    chk("zero_fault_pre", 32'(fault), 32'd0);
    step();
    chk("zero_fault", 32'(fault), 32'd1);
    en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("zero_no_valid", 32'(out_valid), 32'd0);
      chk("zero_sticky",   32'(fault),     32'd1);
    end

    // FFFF fixed point: three words, then repetition fault
    load(16'hFFFF);
    chk("ffff_fault_clr", 32'(fault), 32'd0);
    step();
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("ffff_valid%0d", i), 32'(out_valid), 32'd1);
      chk($sformatf("ffff_word%0d", i),  32'(out_data),  32'hFFFF);
      chk($sformatf("ffff_nf%0d", i),    32'(fault),     32'd0);
    end
    step();
    chk("ffff_fault", 32'(fault),     32'd1);
    chk("ffff_valid", 32'(out_valid), 32'd0);
    load(16'h0001);
    chk("reseed_fault", 32'(fault), 32'd0);
    chk("reseed_busy",  32'(busy),  32'd1);

    // backpressure: 0x0001 <-> 0x7FFC period-2 orbit
    step();
    step();
    chk("bp_first", 32'(out_data), 32'h7FFC);
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bp_hold_valid", 32'(out_valid), 32'd1);
      chk("bp_hold_data",  32'(out_data),  32'h7FFC);
    end
    // five stalled advances leave s at 0x7FFC; release transfers and recaptures
    out_ready = 1'b1;
    step();
    chk("bp_rel_valid", 32'(out_valid), 32'd1);
    chk("bp_rel_data",  32'(out_data),  32'h7FFC);
    chk("bp_rel_fault", 32'(fault),     32'd0);
    step();
    chk("bp_next_data", 32'(out_data),  32'h0001);

    // en=0 mid-warm for 10 cycles delays output by exactly 10 cycles
    load(16'h0001);
    en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("hold_busy",  32'(busy),      32'd1);
      chk("hold_valid", 32'(out_valid), 32'd0);
    end
    en = 1'b1;
    step();
    chk("hold_run_busy", 32'(busy), 32'd0);
    step();
    chk("hold_valid_rise", 32'(out_valid), 32'd1);
    chk("hold_word",       32'(out_data),  32'h7FFC);

    // rst from FAULT restores SEED_RST
    load(16'h0000);
    step();
    chk("flt_pre_rst", 32'(fault), 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("flt_rst_fault", 32'(fault),     32'd0);
    chk("flt_rst_busy",  32'(busy),      32'd1);
    chk("flt_rst_valid", 32'(out_valid), 32'd0);
    step();
    step();
    chk("flt_rst_word", 32'(out_data), 32'h2643);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
